// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a fixed-latency memory.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of data-first priority.
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [2:0]  cnt;
    logic        own_d, own_we, flush_pend;
    logic [31:0] rdata_q;
    logic        arb, pick_d, gnt;
    logic        unused;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_d;
    assign pick_d = d_req && (!if_req || !last_d);
`else
    assign pick_d = d_req;
`endif
    assign arb       = !rst && state != WAIT;
    assign d_gnt     = arb && pick_d;
    assign if_gnt    = arb && if_req && !pick_d;
    assign gnt       = d_gnt || if_gnt;
    assign mem_en    = gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_be    = d_gnt ? d_be : (if_gnt ? 4'hF : 4'h0);
    assign mem_addr  = d_gnt ? d_addr[31:2] : if_addr[31:2];
    assign mem_wdata = d_wdata;
    // Flush gates the fetch response combinationally so it also covers the RESP cycle itself.
    assign if_rvalid = state == RESP && !own_d && !flush_pend && !if_flush;
    assign d_rvalid  = state == RESP && own_d;
    assign if_rdata  = if_rvalid ? rdata_q : 32'h0;
    assign d_rdata   = (d_rvalid && !own_we) ? rdata_q : 32'h0;
    assign unused    = ^{if_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            own_d      <= 1'b0;
            own_we     <= 1'b0;
            flush_pend <= 1'b0;
            rdata_q    <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d     <= 1'b0;
`endif
        end else if (gnt) begin
            state      <= WAIT;
            cnt        <= 3'(MEM_LAT - 1);
            own_d      <= d_gnt;
            own_we     <= d_gnt && d_we;
            flush_pend <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d     <= d_gnt;
`endif
        end else if (state == RESP) begin
            state <= IDLE;
        end else if (state == WAIT) begin
            if (if_flush && !own_d)
                flush_pend <= 1'b1;
            if (cnt == 3'd0) begin
                rdata_q <= mem_rdata;
                state   <= RESP;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LAT=1 (dut1) and MEM_LAT=3 (dut3).
module tb_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 0, if_flush = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  d_be = 0;
    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_wdata1;
    logic [3:0]  mem_be1;
    logic [29:0] mem_addr1;
    logic [31:0] rdata1 = 32'h0;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3;
    logic [31:0] if_rdata3, d_rdata3, mem_wdata3;
    logic [3:0]  mem_be3;
    logic [29:0] mem_addr3;
    logic [31:0] rdata3 = 32'h0;
    logic        wr_valid = 1'b0;
    logic [29:0] wr_addr = 30'h0;
    logic [31:0] wr_word = 32'h0;
    int tests = 0, fails = 0;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(rdata1));

    mem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(rdata3));

    // Memory words read as A000_0000+addr (dut1) / B000_0000+addr (dut3); dut1 keeps one written word.
    function automatic logic [31:0] rd1(input logic [29:0] a);
        return (wr_valid && a == wr_addr) ? wr_word : 32'hA000_0000 + {2'b0, a};
    endfunction

    always @(posedge clk) begin
        logic [31:0] cur;
        if (mem_en1) begin
            cur = rd1(mem_addr1);
            if (mem_we1) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be1[b]) cur[8*b +: 8] = mem_wdata1[8*b +: 8];
                wr_valid <= 1'b1;
                wr_addr  <= mem_addr1;
                wr_word  <= cur;
            end
            rdata1 <= cur;
        end
        if (mem_en3) rdata3 <= 32'hB000_0000 + {2'b0, mem_addr3};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1; if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF;
        #1;
        if ({if_gnt1, d_gnt1, mem_en1, mem_we1, mem_be1, if_rvalid1, d_rvalid1} !== 10'h0) begin
            fails++; $display("FAIL reset_ctl1 got=%h exp=0", {if_gnt1, d_gnt1, mem_en1, mem_we1, mem_be1, if_rvalid1, d_rvalid1});
        end
        tests++;
        if ({if_gnt3, d_gnt3, mem_en3, mem_we3, mem_be3, if_rvalid3, d_rvalid3} !== 10'h0) begin
            fails++; $display("FAIL reset_ctl3 got=%h exp=0", {if_gnt3, d_gnt3, mem_en3, mem_we3, mem_be3, if_rvalid3, d_rvalid3});
        end
        tests++;
        if ({if_rdata1, d_rdata1} !== 64'h0) begin
            fails++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata1, d_rdata1});
        end
        tests++;
        if_req = 0; d_req = 0; d_we = 0; d_be = 0;
        rst = 0;
        tick();
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h10;
        #1;
        if ({if_gnt1, d_gnt1, mem_en1, mem_we1, mem_be1} !== 8'b1010_1111) begin
            fails++; $display("FAIL fetch_grant got=%b exp=10101111", {if_gnt1, d_gnt1, mem_en1, mem_we1, mem_be1});
        end
        tests++;
        if (mem_addr1 !== 30'h4) begin
            fails++; $display("FAIL fetch_addr got=%h exp=4", mem_addr1);
        end
        tests++;
        tick();
        #1;
        if ({if_gnt1, mem_en1, mem_be1, if_rvalid1} !== 7'h0) begin
            fails++; $display("FAIL fetch_wait got=%b exp=0", {if_gnt1, mem_en1, mem_be1, if_rvalid1});
        end
        tests++;
        if_req = 0;
        tick();
        #1;
        if ({if_rvalid1, if_rdata1} !== {1'b1, 32'hA000_0004}) begin
            fails++; $display("FAIL fetch_resp got=%b/%h exp=1/a0000004", if_rvalid1, if_rdata1);
        end
        tests++;
        tick();
        #1;
        if ({if_rvalid1, if_rdata1} !== 33'h0) begin
            fails++; $display("FAIL fetch_pulse got=%b/%h exp=0/0", if_rvalid1, if_rdata1);
        end
        tests++;
    endtask

    task automatic test_write;
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        #1;
        if ({d_gnt1, if_gnt1, mem_en1, mem_we1, mem_be1} !== 8'b1011_0011) begin
            fails++; $display("FAIL write_grant got=%b exp=10110011", {d_gnt1, if_gnt1, mem_en1, mem_we1, mem_be1});
        end
        tests++;
        if ({mem_addr1, mem_wdata1} !== {30'h40, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL write_bus got=%h/%h exp=40/deadbeef", mem_addr1, mem_wdata1);
        end
        tests++;
        tick();
        d_req = 0; d_we = 0;
        tick();
        d_req = 1; d_be = 4'hF;
        #1;
        if ({d_rvalid1, if_rvalid1, d_rdata1} !== {2'b10, 32'h0}) begin
            fails++; $display("FAIL write_ack got=%b%b/%h exp=10/0", d_rvalid1, if_rvalid1, d_rdata1);
        end
        tests++;
        if ({d_gnt1, mem_we1} !== 2'b10) begin
            fails++; $display("FAIL resp_regrant got=%b exp=10", {d_gnt1, mem_we1});
        end
        tests++;
        tick();
        d_req = 0;
        #1;
        if ({d_gnt1, d_rvalid1} !== 2'b00) begin
            fails++; $display("FAIL read_wait got=%b exp=00", {d_gnt1, d_rvalid1});
        end
        tests++;
        tick();
        #1;
        if ({d_rvalid1, d_rdata1} !== {1'b1, 32'hA000_BEEF}) begin
            fails++; $display("FAIL readback got=%b/%h exp=1/a000beef", d_rvalid1, d_rdata1);
        end
        tests++;
        tick();
    endtask

    task automatic test_contention;
        logic [1:0] exp, prev;
        do_reset();
        prev = 2'b00;
        if_req = 1; d_req = 1; d_we = 0; d_be = 4'hF; if_addr = 32'h20; d_addr = 32'h30;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp = (k % 2 == 1) ? 2'b00 : (RR && (k % 4 == 2)) ? 2'b10 : 2'b01;
            if ({if_gnt1, d_gnt1} !== exp) begin
                fails++; $display("FAIL contend_gnt%0d got=%b exp=%b", k, {if_gnt1, d_gnt1}, exp);
            end
            tests++;
            if (k >= 2 && k % 2 == 0) begin
                if ({if_rvalid1, d_rvalid1} !== prev) begin
                    fails++; $display("FAIL contend_rv%0d got=%b exp=%b", k, {if_rvalid1, d_rvalid1}, prev);
                end
                tests++;
            end
            if (k % 2 == 0) prev = exp;
            tick();
        end
        if_req = 0; d_req = 0;
        tick(); tick();
    endtask

    task automatic test_flush;
        do_reset();
        if_req = 1; if_addr = 32'h20;
        #1;
        if (if_gnt3 !== 1'b1) begin
            fails++; $display("FAIL lat3_gnt got=%b exp=1", if_gnt3);
        end
        tests++;
        tick();
        if_req = 0;
        for (int c = 1; c < 4; c++) begin
            #1;
            if (if_rvalid3 !== 1'b0) begin
                fails++; $display("FAIL lat3_early%0d got=%b exp=0", c, if_rvalid3);
            end
            tests++;
            tick();
        end
        #1;
        if ({if_rvalid3, if_rdata3} !== {1'b1, 32'hB000_0008}) begin
            fails++; $display("FAIL lat3_resp got=%b/%h exp=1/b0000008", if_rvalid3, if_rdata3);
        end
        tests++;
        tick();
        if_req = 1; if_addr = 32'h24;
        tick();
        if_req = 0; if_flush = 1;
        tick();
        if_flush = 0;
        tick(); tick();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h8;
        #1;
        if ({if_rvalid3, if_rdata3} !== 33'h0) begin
            fails++; $display("FAIL flush_supp got=%b/%h exp=0/0", if_rvalid3, if_rdata3);
        end
        tests++;
        if (d_gnt3 !== 1'b1) begin
            fails++; $display("FAIL flush_dgnt got=%b exp=1", d_gnt3);
        end
        tests++;
        tick();
        d_req = 0;
        tick(); tick(); tick();
        #1;
        if ({d_rvalid3, d_rdata3} !== {1'b1, 32'hB000_0002}) begin
            fails++; $display("FAIL flush_data got=%b/%h exp=1/b0000002", d_rvalid3, d_rdata3);
        end
        tests++;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        if_req = 1; if_addr = 32'h10;
        #1;
        if (if_gnt1 !== 1'b1) begin
            fails++; $display("FAIL mid_gnt got=%b exp=1", if_gnt1);
        end
        tests++;
        tick();
        rst = 1;
        #1;
        if ({if_gnt1, d_gnt1, mem_en1, if_rvalid1, d_rvalid1, if_rdata1} !== 37'h0) begin
            fails++; $display("FAIL mid_rst got=%h exp=0", {if_gnt1, d_gnt1, mem_en1, if_rvalid1, d_rvalid1, if_rdata1});
        end
        tests++;
        tick();
        rst = 0; if_req = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (if_rvalid1 !== 1'b0) begin
                fails++; $display("FAIL mid_drop%0d got=%b exp=0", c, if_rvalid1);
            end
            tests++;
            tick();
        end
        if_req = 1;
        #1;
        if (if_gnt1 !== 1'b1) begin
            fails++; $display("FAIL mid_regrant got=%b exp=1", if_gnt1);
        end
        tests++;
        tick();
        if_req = 0;
        tick(); tick();
    endtask

    initial begin
        tick(); tick();
        test_reset();
        test_fetch();
        test_write();
        test_contention();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
